// File: rtl/alu_arbiter_pkg.sv
// ============================================================================
// Module      : alu_arbiter_pkg
// Description : Shared definitions for the two-requester ALU arbiter.
//               Holds the datapath word width, the ALU operation encodings
//               and the request bundle type used by the arbiter top and
//               its ALU sub-block.
// Contents    : WORD_W     - datapath width in bits
//               alu_op_e   - 2-bit ALU operation code (ADD/SUB/AND/XOR)
//               alu_req_t  - one requester's operation bundle
//               sign_of()  - helper returning the sign bit of a word
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_arbiter_pkg;

  // Datapath width shared by the arbiter and the ALU.
  localparam int WORD_W = 64;

  // Index of the sign bit.
  localparam int WORD_MSB = WORD_W - 1;

  // ALU operation encodings, fixed by the requester interface.
  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_XOR = 2'b11
  } alu_op_e;

  // One requester's operation, gathered so the grant mux is a single select.
  typedef struct packed {
    alu_op_e           op;
    logic [WORD_W-1:0] a;
    logic [WORD_W-1:0] b;
    logic              setcc;
  } alu_req_t;

  // Sign bit of a two's-complement word.
  function automatic logic sign_of(input logic [WORD_W-1:0] w);
    return w[WORD_MSB];
  endfunction

endpackage : alu_arbiter_pkg

`default_nettype wire

// File: rtl/alu_arbiter_alu.sv
// ============================================================================
// Module      : alu_arbiter_alu
// Description : Purely combinational 64-bit ALU shared by both requesters
//               of alu_arbiter. Results wrap modulo 2^64; the overflow flag
//               reports signed overflow for ADD/SUB and is 0 for AND/XOR.
// Ports       : op_i     in   operation code (alu_op_e)
//               a_i      in   operand A (two's complement)
//               b_i      in   operand B (two's complement)
//               result_o out  wrapped result
//               of_o     out  signed overflow flag
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_arbiter_alu
  import alu_arbiter_pkg::*;
(
  input  alu_op_e           op_i,
  input  logic [WORD_W-1:0] a_i,
  input  logic [WORD_W-1:0] b_i,
  output logic [WORD_W-1:0] result_o,
  output logic              of_o
);

  logic sa;
  logic sb;
  logic sr;

  assign sa = sign_of(a_i);
  assign sb = sign_of(b_i);
  assign sr = sign_of(result_o);

  always_comb begin
    result_o = '0;
    of_o     = 1'b0;
    case (op_i)
      ALU_ADD: begin
        result_o = a_i + b_i;
        // Two same-signed operands produced a result of the other sign.
        of_o     = (sa == sb) && (sr != sa);
      end
      ALU_SUB: begin
        result_o = a_i - b_i;
        // Operands of opposite sign produced a result whose sign left A's.
        of_o     = (sa != sb) && (sr != sa);
      end
      ALU_AND: begin
        result_o = a_i & b_i;
        of_o     = 1'b0;
      end
      ALU_XOR: begin
        result_o = a_i ^ b_i;
        of_o     = 1'b0;
      end
      default: begin
        result_o = '0;
        of_o     = 1'b0;
      end
    endcase
  end

endmodule : alu_arbiter_alu

`default_nettype wire

// File: rtl/alu_arbiter.sv
// ============================================================================
// Module      : alu_arbiter
// Description : Two requesters share one combinational ALU. An arbiter picks
//               at most one request per cycle (round-robin or fixed priority),
//               the chosen operation is computed and captured in a single
//               output register presented on a valid/ready response port.
//               An optional condition-code register (ZF/SF/OF) is loaded by
//               transfers that carry setcc=1.
// Parameters  : PRIO_FIXED   0 = round-robin, 1 = requester 0 always wins
// Macro       : ALU_ARBITER_CC_EN - when defined, builds the condition-code
//               register; otherwise cc_* are tied to their reset values
//               and reqN_setcc is ignored.
// Ports       : clk, rst_n                 clock, async active-low reset
//               reqN_valid / reqN_ready    per-requester handshake (N=0,1)
//               reqN_op/_a/_b/_setcc       per-requester operation
//               rsp_valid / rsp_ready      response handshake
//               rsp_id/_result/_of         winning id, result, overflow
//               cc_zf, cc_sf, cc_of        condition codes
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int PRIO_FIXED = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,

  input  logic                     req0_valid,
  output logic                     req0_ready,
  input  logic [1:0]               req0_op,
  input  logic signed [WORD_W-1:0] req0_a,
  input  logic signed [WORD_W-1:0] req0_b,
  input  logic                     req0_setcc,

  input  logic                     req1_valid,
  output logic                     req1_ready,
  input  logic [1:0]               req1_op,
  input  logic signed [WORD_W-1:0] req1_a,
  input  logic signed [WORD_W-1:0] req1_b,
  input  logic                     req1_setcc,

  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic                     rsp_id,
  output logic [WORD_W-1:0]        rsp_result,
  output logic                     rsp_of,

  output logic                     cc_zf,
  output logic                     cc_sf,
  output logic                     cc_of
);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic              rsp_valid_q,  rsp_valid_d;
  logic              rsp_id_q,     rsp_id_d;
  logic [WORD_W-1:0] rsp_result_q, rsp_result_d;
  logic              rsp_of_q,     rsp_of_d;
  logic              rr_q,         rr_d;

  // --------------------------------------------------------------------------
  // Arbitration
  // --------------------------------------------------------------------------
  logic out_free;
  logic grant_id;
  logic xfer;

  // The output register can take a new result when empty or being drained
  // in this very cycle.
  assign out_free = ~rsp_valid_q | rsp_ready;

  generate
    if (PRIO_FIXED != 0) begin : g_prio_fixed
      always_comb begin
        grant_id = 1'b0;
        if (!req0_valid && req1_valid) begin
          grant_id = 1'b1;
        end
      end
    end else begin : g_prio_rr
      // With both (or neither) requesting, the pointer decides.
      always_comb begin
        grant_id = rr_q;
        if (req0_valid && !req1_valid) begin
          grant_id = 1'b0;
        end else if (!req0_valid && req1_valid) begin
          grant_id = 1'b1;
        end
      end
    end
  endgenerate

  // rst_n gates ready combinationally so nothing can be accepted while the
  // design is held in reset, even though the output register reads as free.
  assign req0_ready = rst_n & out_free & req0_valid & (grant_id == 1'b0);
  assign req1_ready = rst_n & out_free & req1_valid & (grant_id == 1'b1);
  assign xfer       = req0_ready | req1_ready;

  // --------------------------------------------------------------------------
  // Operand select and shared ALU
  // --------------------------------------------------------------------------
  alu_req_t          req0_bus;
  alu_req_t          req1_bus;
  alu_req_t          sel_req;
  logic [WORD_W-1:0] alu_result;
  logic              alu_of;

  assign req0_bus = '{op: alu_op_e'(req0_op), a: req0_a, b: req0_b, setcc: req0_setcc};
  assign req1_bus = '{op: alu_op_e'(req1_op), a: req1_a, b: req1_b, setcc: req1_setcc};
  assign sel_req  = grant_id ? req1_bus : req0_bus;

  alu_arbiter_alu u_alu (
    .op_i     (sel_req.op),
    .a_i      (sel_req.a),
    .b_i      (sel_req.b),
    .result_o (alu_result),
    .of_o     (alu_of)
  );

  // --------------------------------------------------------------------------
  // Output register and round-robin pointer
  // --------------------------------------------------------------------------
  always_comb begin
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_result_d = rsp_result_q;
    rsp_of_d     = rsp_of_q;
    rr_d         = rr_q;
    if (xfer) begin
      rsp_valid_d  = 1'b1;
      rsp_id_d     = grant_id;
      rsp_result_d = alu_result;
      rsp_of_d     = alu_of;
      // Hand priority to the requester that just lost (or was idle).
      rr_d         = ~grant_id;
    end else if (rsp_ready) begin
      rsp_valid_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_result_q <= '0;
      rsp_of_q     <= 1'b0;
      rr_q         <= 1'b0;
    end else begin
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
      rsp_of_q     <= rsp_of_d;
      rr_q         <= rr_d;
    end
  end

  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_result = rsp_result_q;
  assign rsp_of     = rsp_of_q;

  // --------------------------------------------------------------------------
  // Condition-code register
  // --------------------------------------------------------------------------
`ifdef ALU_ARBITER_CC_EN
  logic cc_zf_q, cc_zf_d;
  logic cc_sf_q, cc_sf_d;
  logic cc_of_q, cc_of_d;

  // Loaded on the same edge as the response register, from the same ALU
  // outputs, so flags and result always describe the same operation.
  always_comb begin
    cc_zf_d = cc_zf_q;
    cc_sf_d = cc_sf_q;
    cc_of_d = cc_of_q;
    if (xfer && sel_req.setcc) begin
      cc_zf_d = (alu_result == '0);
      cc_sf_d = sign_of(alu_result);
      cc_of_d = alu_of;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cc_zf_q <= 1'b1;
      cc_sf_q <= 1'b0;
      cc_of_q <= 1'b0;
    end else begin
      cc_zf_q <= cc_zf_d;
      cc_sf_q <= cc_sf_d;
      cc_of_q <= cc_of_d;
    end
  end

  assign cc_zf = cc_zf_q;
  assign cc_sf = cc_sf_q;
  assign cc_of = cc_of_q;
`else
  // Without the register the flags read as their reset values and setcc
  // has no effect.
  logic w_unused_setcc;
  assign w_unused_setcc = sel_req.setcc;

  assign cc_zf = 1'b1;
  assign cc_sf = 1'b0;
  assign cc_of = 1'b0;
`endif

endmodule : alu_arbiter

`default_nettype wire

// File: tb/tb_alu_arbiter.sv
// ============================================================================
// Module      : tb_alu_arbiter
// Description : Self-checking bench for alu_arbiter. A driver issues directed
//               and random requests, predicts each accepted operation with a
//               behavioural model and queues the expected response; a
//               separate monitor pops and compares whenever a response is
//               presented. A second fixed-priority instance is fed two
//               permanently valid requesters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_arbiter;

  typedef struct packed {
    logic [1:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    logic        setcc;
  } req_t;

  typedef struct packed {
    logic        id;
    logic [63:0] res;
    logic        of;
    logic        zf;
    logic        sf;
    logic        ccof;
  } exp_t;

  // --------------------------------------------------------------------------
  // DUT signals (round-robin instance)
  // --------------------------------------------------------------------------
  logic        clk;
  logic        rst_n;
  logic        req0_valid, req0_ready, req0_setcc;
  logic [1:0]  req0_op;
  logic [63:0] req0_a, req0_b;
  logic        req1_valid, req1_ready, req1_setcc;
  logic [1:0]  req1_op;
  logic [63:0] req1_a, req1_b;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_of;
  logic [63:0] rsp_result;
  logic        cc_zf, cc_sf, cc_of;

  // Fixed-priority instance
  logic        f_req0_valid, f_req0_ready, f_req1_valid, f_req1_ready;
  logic        f_rsp_valid, f_rsp_id, f_rsp_of;
  logic [63:0] f_rsp_result;
  logic        f_cc_zf, f_cc_sf, f_cc_of;

  alu_arbiter #(.PRIO_FIXED(0)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b), .req0_setcc(req0_setcc),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b), .req1_setcc(req1_setcc),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_of(rsp_of),
    .cc_zf(cc_zf), .cc_sf(cc_sf), .cc_of(cc_of)
  );

  alu_arbiter #(.PRIO_FIXED(1)) u_dut_fixed (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(f_req0_valid), .req0_ready(f_req0_ready), .req0_op(2'b00),
    .req0_a(64'd53), .req0_b(64'd22), .req0_setcc(1'b0),
    .req1_valid(f_req1_valid), .req1_ready(f_req1_ready), .req1_op(2'b01),
    .req1_a(64'd9), .req1_b(64'd4), .req1_setcc(1'b0),
    .rsp_valid(f_rsp_valid), .rsp_ready(1'b1), .rsp_id(f_rsp_id),
    .rsp_result(f_rsp_result), .rsp_of(f_rsp_of),
    .cc_zf(f_cc_zf), .cc_sf(f_cc_sf), .cc_of(f_cc_of)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // --------------------------------------------------------------------------
  // Bookkeeping and model state
  // --------------------------------------------------------------------------
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   mon_en  = 0;
  int   rst_epoch = 0;
  int   rand_pct = 0;

  exp_t sb[$];
  req_t dq0[$];
  req_t dq1[$];

  bit   pv[2];
  req_t pr[2];
  bit   m_out_valid = 0;
  bit   m_rr = 0;
  bit   m_zf = 1, m_sf = 0, m_of = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] rand64();
    case ($urandom_range(7))
      0: return 64'h0;
      1: return 64'h7FFF_FFFF_FFFF_FFFF;
      2: return 64'h8000_0000_0000_0000;
      3: return 64'hFFFF_FFFF_FFFF_FFFF;
      4: return 64'(longint'($urandom_range(100)));
      default: return {$urandom, $urandom};
    endcase
  endfunction

  task automatic load(input int n);
    req_t r;
    if (n == 0 && dq0.size() > 0) begin
      r = dq0.pop_front();
    end else if (n == 1 && dq1.size() > 0) begin
      r = dq1.pop_front();
    end else if ($urandom_range(99) < rand_pct) begin
      r.op = 2'($urandom_range(3));
      r.a = rand64();
      r.b = rand64();
      r.setcc = 1'($urandom_range(1));
    end else begin
      return;
    end
    pv[n] = 1'b1;
    pr[n] = r;
  endtask

  task automatic drive();
    req0_valid = pv[0]; req0_op = pr[0].op; req0_a = pr[0].a; req0_b = pr[0].b; req0_setcc = pr[0].setcc;
    req1_valid = pv[1]; req1_op = pr[1].op; req1_a = pr[1].a; req1_b = pr[1].b; req1_setcc = pr[1].setcc;
  endtask

  // Reference arithmetic: exact signed value in 65 bits, overflow when it
  // does not fit in 64.
  function automatic exp_t predict(input req_t r, input logic id);
    exp_t        e;
    logic [64:0] wa, wb, w;
    wa = {r.a[63], r.a};
    wb = {r.b[63], r.b};
    case (r.op)
      2'b00:   w = wa + wb;
      2'b01:   w = wa - wb;
      2'b10:   w = {1'b0, r.a & r.b};
      default: w = {1'b0, r.a ^ r.b};
    endcase
    e.id  = id;
    e.res = w[63:0];
    e.of  = (r.op <= 2'b01) ? (w[64] ^ w[63]) : 1'b0;
`ifdef ALU_ARBITER_CC_EN
    if (r.setcc) begin
      m_zf = (e.res == 64'd0);
      m_sf = e.res[63];
      m_of = e.of;
    end
`endif
    e.zf = m_zf; e.sf = m_sf; e.ccof = m_of;
    return e;
  endfunction

  // One clock: drive at the falling edge, predict just before the rising edge.
  task automatic cycle(input bit rdy);
    bit free, g, x0, x1;
    @(negedge clk);
    rsp_ready = rdy;
    for (int n = 0; n < 2; n++) if (!pv[n]) load(n);
    drive();
    #4;
    free = !m_out_valid || rdy;
    if (pv[0] && pv[1]) g = m_rr;
    else                g = pv[1];
    x0 = free && pv[0] && !g;
    x1 = free && pv[1] && g;
    chk("req0_ready", {63'd0, req0_ready}, {63'd0, x0});
    chk("req1_ready", {63'd0, req1_ready}, {63'd0, x1});
    if (x0 || x1) begin
      sb.push_back(predict(pr[g], g));
      m_rr = !g;
      pv[g] = 1'b0;
      m_out_valid = 1'b1;
    end else if (rdy) begin
      m_out_valid = 1'b0;
    end
  endtask

  // --------------------------------------------------------------------------
  // Monitor
  // --------------------------------------------------------------------------
  initial begin : monitor
    exp_t        e;
    bit          hold_prev;
    logic [63:0] prev_res;
    int          seen_epoch;
    hold_prev  = 0;
    prev_res   = '0;
    seen_epoch = 0;
    forever begin
      @(negedge clk);
      #3;
      if (seen_epoch != rst_epoch) begin
        hold_prev  = 0;
        seen_epoch = rst_epoch;
      end
      if (mon_en && rst_n) begin
        chk("rsp_valid", {63'd0, rsp_valid}, {63'd0, sb.size() != 0});
        if (hold_prev) chk("held_result", rsp_result, prev_res);
        hold_prev = 0;
        if (rsp_valid && sb.size() != 0) begin
          e = sb[0];
          chk("rsp_id", {63'd0, rsp_id}, {63'd0, e.id});
          chk("rsp_result", rsp_result, e.res);
          chk("rsp_of", {63'd0, rsp_of}, {63'd0, e.of});
          chk("cc_zf", {63'd0, cc_zf}, {63'd0, e.zf});
          chk("cc_sf", {63'd0, cc_sf}, {63'd0, e.sf});
          chk("cc_of", {63'd0, cc_of}, {63'd0, e.ccof});
          if (rsp_ready) begin
            void'(sb.pop_front());
          end else begin
            hold_prev = 1;
            prev_res  = rsp_result;
          end
        end
        if (f_rsp_valid) begin
          chk("fixed_id", {63'd0, f_rsp_id}, 64'd0);
          chk("fixed_result", f_rsp_result, 64'd75);
        end
        chk("fixed_req1_ready", {63'd0, f_req1_ready}, 64'd0);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  task automatic reset_checks(input string tag);
    chk({tag, "_rsp_valid"}, {63'd0, rsp_valid}, 64'd0);
    chk({tag, "_rsp_result"}, rsp_result, 64'd0);
    chk({tag, "_rsp_of"}, {63'd0, rsp_of}, 64'd0);
    chk({tag, "_rsp_id"}, {63'd0, rsp_id}, 64'd0);
    chk({tag, "_cc_zf"}, {63'd0, cc_zf}, 64'd1);
    chk({tag, "_cc_sf"}, {63'd0, cc_sf}, 64'd0);
    chk({tag, "_cc_of"}, {63'd0, cc_of}, 64'd0);
    chk({tag, "_req0_ready"}, {63'd0, req0_ready}, 64'd0);
    chk({tag, "_req1_ready"}, {63'd0, req1_ready}, 64'd0);
    chk({tag, "_f_req0_ready"}, {63'd0, f_req0_ready}, 64'd0);
  endtask

  task automatic model_reset();
    sb.delete();
    pv[0] = 0; pv[1] = 0;
    m_out_valid = 0; m_rr = 0;
    m_zf = 1; m_sf = 0; m_of = 0;
  endtask

  initial begin : main
    rst_n = 1'b0;
    rsp_ready = 1'b0;
    f_req0_valid = 1'b1;
    f_req1_valid = 1'b1;
    pr[0] = '0; pr[1] = '0;
    model_reset();
    drive();
    // Requests held valid during reset must not be accepted.
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    repeat (2) @(negedge clk);
    #2;
    reset_checks("reset");
    drive();
    #1 rst_n = 1'b1;
    mon_en = 1;

    // Basic add with flags.
    dq0.push_back('{op: 2'b00, a: 64'd53, b: 64'd22, setcc: 1'b1});
    repeat (3) cycle(1);

    // Signed overflow boundaries.
    dq0.push_back('{op: 2'b00, a: 64'h7FFF_FFFF_FFFF_FFFF, b: 64'd1, setcc: 1'b1});
    dq0.push_back('{op: 2'b01, a: 64'h7FFF_FFFF_FFFF_FFFF, b: 64'hFFFF_FFFF_FFFF_FFFF, setcc: 1'b1});
    repeat (4) cycle(1);

    // Back-pressure: result held, nobody accepted, then drained and refilled.
    dq1.push_back('{op: 2'b01, a: 64'd53, b: 64'd22, setcc: 1'b0});
    cycle(1);
    dq0.push_back('{op: 2'b10, a: 64'hF0F0, b: 64'h0FF0, setcc: 1'b0});
    repeat (3) cycle(0);
    repeat (3) cycle(1);

    // Zero result: flags untouched without setcc, ZF set with it.
    dq0.push_back('{op: 2'b11, a: 64'h35, b: 64'h35, setcc: 1'b0});
    dq0.push_back('{op: 2'b11, a: 64'h35, b: 64'h35, setcc: 1'b1});
    repeat (4) cycle(1);

    // Both requesters always valid: round-robin alternation.
    rand_pct = 100;
    repeat (10) cycle(1);

    // Random traffic with random back-pressure.
    rand_pct = 60;
    repeat (400) cycle($urandom_range(3) != 0);

    // Asynchronous reset while a response is pending.
    rand_pct = 100;
    repeat (3) cycle(1);
    cycle(0);
    #3;
    mon_en = 0;
    rst_n  = 1'b0;
    rst_epoch++;
    #1;
    reset_checks("async_reset");
    model_reset();
    rand_pct = 0;
    drive();
    @(negedge clk);
    #1 rst_n = 1'b1;
    mon_en = 1;

    // Accepting resumes in the first cycle after reset.
    dq0.push_back('{op: 2'b00, a: 64'd53, b: 64'd22, setcc: 1'b1});
    repeat (4) cycle(1);

    @(negedge clk);
    #3;
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule : tb_alu_arbiter

`default_nettype wire

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter PRIO_FIXED, default 0: 0 = round-robin grant, 1 = requester 0 always wins.
REQ-002 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset; asynchronous, active-low.
REQ-004 SHALL have ports reqN_valid  input  1 and reqN_ready  output  1, N = 0,1: per-requester handshake.
REQ-005 SHALL have ports reqN_op  input  2, reqN_a  input  64 (signed), reqN_b  input  64 (signed), reqN_setcc  input  1: operation; op 00 add, 01 sub (a-b), 10 and, 11 xor.
REQ-006 SHALL have ports rsp_valid  output  1, rsp_ready  input  1, rsp_id  output  1 (winning requester), rsp_result  output  64, rsp_of  output  1.
REQ-007 SHALL have ports cc_zf, cc_sf, cc_of  output  1 each: condition-code register (see Configuration).

Function
REQ-008 SHALL share one combinational ALU between both requesters; at most one operation accepted per cycle.
REQ-009 SHALL treat the output register as free when rsp_valid=0 or rsp_ready=1 in the same cycle.
REQ-010 SHALL assert reqN_ready only for the granted requester and only when the output register is free; transfer = valid & ready on a rising edge.
REQ-011 SHALL grant the sole valid requester; with both valid: PRIO_FIXED=1 -> requester 0; PRIO_FIXED=0 -> requester named by rr pointer.
REQ-012 SHALL move rr pointer to the non-granted requester after every transfer; no transfer -> pointer unchanged.
REQ-013 SHALL register result, OF and id on the transfer edge; rsp_valid rises the cycle after acceptance (latency 1).
REQ-014 SHALL hold rsp_result, rsp_of, rsp_id, rsp_valid stable while rsp_valid=1 and rsp_ready=0.
REQ-015 SHALL sustain one result per cycle when rsp_ready held high and a request valid every cycle.
REQ-016 SHALL compute 64-bit wrap-around results; OF add = a,b same sign and result sign differs; OF sub = a,b signs differ and result sign differs from a; OF and/xor = 0.
REQ-017 SHALL deassert rsp_valid after a handshake when no new transfer occurs in that cycle.
REQ-018 SHALL, while a request is not granted, not require its inputs stable; requester keeps valid high until ready.

Reset
REQ-019 SHALL on rst_n low, immediately: rsp_valid=0, rsp_result=0, rsp_of=0, rsp_id=0, rr pointer=0, cc_zf=1, cc_sf=0, cc_of=0.
REQ-020 SHALL drive req0_ready=req1_ready=0 while rst_n low; a pending response is discarded by reset mid-operation.
REQ-021 SHALL resume accepting in the first cycle after rst_n deasserts.

Configuration
REQ-022 SHALL compile the condition-code register only when macro ALU_ARBITER_CC_EN is defined.
REQ-023 SHALL, with ALU_ARBITER_CC_EN, on a transfer with setcc=1 load ZF=(result==0), SF=result[63], OF=computed OF on the same edge as the result; setcc=0 leaves CC unchanged.
REQ-024 SHALL, without ALU_ARBITER_CC_EN, tie cc_zf=1, cc_sf=0, cc_of=0 and ignore reqN_setcc.

Structure
REQ-025 SHALL place ALU op encodings (ADD, SUB, AND, XOR) and the 64-bit word width constant in a shared package used by both blocks.
REQ-026 SHALL instantiate the existing alu_ block as its single sub-module; arbiter, output register and CC register remain in alu_arbiter.

Verification
REQ-027 SHALL cover: req0 op=00 a=53 b=22 setcc=1 -> next cycle rsp_valid=1 id=0 result=75 of=0; ZF=0 SF=0.
REQ-028 SHALL cover: req0 and req1 valid continuously, rsp_ready=1, PRIO_FIXED=0 -> ids 0,1,0,1 on consecutive cycles; PRIO_FIXED=1 -> all 0.
REQ-029 SHALL cover: rsp_ready=0 for 3 cycles after req1 op=01 a=53 b=22 -> result=31 held, both reqN_ready=0; rsp_ready=1 -> handshake, next request accepted same cycle.
REQ-030 SHALL cover: op=00 a=0x7FFFFFFFFFFFFFFF b=1 setcc=1 -> result=0x8000000000000000, of=1, SF=1, ZF=0; op=01 same a, b=-1 -> of=1.
REQ-031 SHALL cover: op=11 a=b=0x35 setcc=0 -> result=0, CC unchanged; then setcc=1 -> ZF=1; rst_n pulsed with rsp_valid=1 -> rsp_valid=0, CC at reset values asynchronously.
